sinegen_ctrl: RTL and testbench
===============================

Name: sinegen_ctrl

Overview:
Address sequencer and sample capture for the dual-port sine ROM. A phase accumulator drives the ROM base address. A phase-offset register drives the ROM offset port; the ROM adds it to the base address internally. The block registers both ROM outputs with a matching valid strobe. Frequency and offset are reconfigured through a valid/ready handshake; mid-run changes take effect only at phase wrap, so output waveforms stay glitch-free.

Parameters:
ADDRESS_WIDTH, 8, phase/ROM address width (A)
DATA_WIDTH, 8, ROM sample width (D)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  run request (level)
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept; handshake when cfg_valid & cfg_ready at posedge
cfg_incr  in  A  phase increment per cycle
cfg_offset  in  A  phase offset for second channel
addr1  out  A  ROM base address (registered phase accumulator)
addr2  out  A  ROM offset address (registered offset register)
rom_dout1  in  D  ROM data, base channel (1-cycle registered ROM)
rom_dout2  in  D  ROM data, offset channel
sample1  out  D  registered base-channel sample
sample2  out  D  registered offset-channel sample
sample_valid  out  1  sample1/sample2 valid this cycle
wrap  out  1  one-cycle pulse: addr1 holds a wrapped phase
busy  out  1  state is RUN or DRAIN

Behaviour:
- Reset (async, rst=0): state IDLE, phase=0, incr=1, offset=0, pending=0.
- Reset values of outputs: addr1=0, addr2=0, cfg_ready=1, sample1/2=0, sample_valid=0, wrap=0, busy=0.
- Reset mid-operation clears everything immediately, without a clock edge. Any in-flight samples are discarded.
- FSM states:
  - IDLE: phase holds. cfg_ready=1. A handshake loads incr and offset directly, with no pending. en=1 -> RUN next cycle.
  - RUN: each cycle phase <= (phase+incr) mod 2^A. en=0 -> DRAIN.
  - DRAIN: phase holds. Lasts exactly 2 cycles, then IDLE. en is ignored in DRAIN. IDLE re-enters RUN on the following edge if en=1.
- Phase is retained across stop/start; resume continues from the held addr1.
- Wrap detection: wrap=1 in the cycle the post-carry phase is on addr1. Carry means phase+incr >= 2^A.
- incr=0: phase constant, no wrap, samples still produced each RUN cycle.
- Config in RUN/DRAIN:
  - cfg_ready = !pending.
  - A handshake stores cfg_incr/cfg_offset into pending registers and sets pending.
  - Pending is applied on the posedge that produces a wrap. The wrapping step uses the old incr. The new offset appears on addr2 in the same cycle as the wrapped addr1.
  - Pending is also applied on the DRAIN->IDLE transition.
  - A handshake in the same cycle as a wrap edge becomes pending. It is not applied on that edge.
  - cfg_ready returns to 1 the cycle after pending is applied.
- Latency: the address pair issued in RUN cycle t gives rom_dout valid at t+1. sample1/2 are registered, with sample_valid=1 at t+2.
  - Valid pipeline: v1 <= (state==RUN); sample_valid <= v1.
  - After en falls, exactly the samples of addresses issued in RUN emerge. The 2-cycle DRAIN covers them.
- sample1/2 hold their last value when sample_valid=0.
- Arithmetic is modulo 2^A; the carry is used only for wrap. The controller never adds addr1+addr2; the ROM does that.

Test Plan:
1. Reset, then en=1 with defaults: addr1 = 0,1,2,…,255,0. wrap high only on the cycle addr1 returns to 0. sample_valid first high 2 cycles after the first RUN cycle, with sample1=rom[0] and sample2=rom[0].
2. In IDLE, cfg incr=64, offset=32, then en=1: addr1 = 0,64,128,192,0,… with wrap at each 0. addr2=32. sample2 = rom[addr1+32].
3. RUN with incr=1, cfg incr=3 offset=16 at addr1=250: cfg_ready=0 next cycle. Sequence is 251…255, then 0 with wrap=1 and addr2=16, then 3,6,9. cfg_ready=1 the cycle after the wrap.
4. Handshake coincident with a wrap edge (incr=128, phase 128->0): config is not applied at that 0. It is applied at the next wrap (0->128->0).
5. en=0 at addr1=40 (incr=1): exactly 2 further sample_valid pulses. busy falls after 2 DRAIN cycles. en=1 resumes at addr1=41.
6. rst asserted low asynchronously mid-RUN: addr1, addr2, sample_valid, busy and wrap go to 0 before the next clock edge. After release, the block is in IDLE with incr=1.

Source files
------------

// File: rtl/sinegen_ctrl.sv
// Phase-accumulator address sequencer and two-channel sample capture for a dual-port sine ROM.
// Frequency/offset reconfiguration in RUN/DRAIN is deferred to a phase wrap so waveforms stay glitch-free.
module sinegen_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ADDRESS_WIDTH-1:0] cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [ADDRESS_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0]    rom_dout1,
  input  logic [DATA_WIDTH-1:0]    rom_dout2,
  output logic [DATA_WIDTH-1:0]    sample1,
  output logic [DATA_WIDTH-1:0]    sample2,
  output logic                     sample_valid,
  output logic                     wrap,
  output logic                     busy
);

  // DRAIN length matches the ROM + capture latency so every issued address is sampled.
  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned CNT_W        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [CNT_W-1:0]         drain_cnt;
  logic [CNT_W-1:0]         drain_cnt_next;

  logic [ADDRESS_WIDTH-1:0] phase;
  logic [ADDRESS_WIDTH-1:0] incr;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [ADDRESS_WIDTH-1:0] pend_incr;
  logic [ADDRESS_WIDTH-1:0] pend_offset;
  logic                     pending;
  logic                     pending_next;
  logic                     v1;

  logic [ADDRESS_WIDTH:0]   sum;
  logic                     hs;
  logic                     step;
  logic                     wrap_step;
  logic                     drain_done;
  logic                     apply_pend;
  logic                     load_direct;
  logic                     pend_set;

  assign addr1 = phase;
  assign addr2 = offset;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Next state and datapath control strobes
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    sum            = {1'b0, phase} + {1'b0, incr};
    hs             = cfg_valid & cfg_ready;
    step           = (state == RUN);
    wrap_step      = step & sum[ADDRESS_WIDTH];
    drain_done     = (state == DRAIN) && (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));
    apply_pend     = pending & (wrap_step | drain_done);
    // Config arriving on the DRAIN->IDLE edge is loaded straight away, as it would be in IDLE.
    load_direct    = hs & ((state == IDLE) | drain_done);
    pend_set       = hs & ~load_direct;
    pending_next   = (pending & ~apply_pend) | pend_set;

    case (state)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en) begin
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end
      end
      DRAIN: begin
        if (drain_done) state_next = IDLE;
        else            drain_cnt_next = drain_cnt + CNT_W'(1);
      end
      default: begin
        state_next     = IDLE;
        drain_cnt_next = '0;
      end
    endcase
  end

  // Phase, configuration and sample pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase        <= '0;
      incr         <= ADDRESS_WIDTH'(1);
      offset       <= '0;
      pend_incr    <= '0;
      pend_offset  <= '0;
      pending      <= 1'b0;
      cfg_ready    <= 1'b1;
      wrap         <= 1'b0;
      busy         <= 1'b0;
      v1           <= 1'b0;
      sample_valid <= 1'b0;
      sample1      <= '0;
      sample2      <= '0;
    end else begin
      if (step) phase <= sum[ADDRESS_WIDTH-1:0];

      if (load_direct) begin
        incr   <= cfg_incr;
        offset <= cfg_offset;
      end else if (apply_pend) begin
        incr   <= pend_incr;
        offset <= pend_offset;
      end

      if (pend_set) begin
        pend_incr   <= cfg_incr;
        pend_offset <= cfg_offset;
      end

      pending      <= pending_next;
      cfg_ready    <= ~pending_next;
      wrap         <= wrap_step;
      busy         <= (state_next != IDLE);
      v1           <= step;
      sample_valid <= v1;
      if (v1) begin
        sample1 <= rom_dout1;
        sample2 <= rom_dout2;
      end
    end
  end

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Bench for sinegen_ctrl: a registered ROM model feeds the DUT, expected samples are queued per
// issued address and matched by a monitor; scenario tasks check addresses, wrap and handshake inline.
module tb_sinegen_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_incr = 8'd0;
  logic [7:0] cfg_offset = 8'd0;
  logic [7:0] addr1, addr2;
  logic [7:0] rom_dout1 = 8'd0;
  logic [7:0] rom_dout2 = 8'd0;
  logic [7:0] sample1, sample2;
  logic       sample_valid, wrap, busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] e1, e2;

  sinegen_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_incr(cfg_incr), .cfg_offset(cfg_offset), .addr1(addr1), .addr2(addr2),
    .rom_dout1(rom_dout1), .rom_dout2(rom_dout2), .sample1(sample1), .sample2(sample2),
    .sample_valid(sample_valid), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return (a * 8'd37) + 8'd11;
  endfunction

  // Dual-port ROM model: one-cycle registered read, offset added inside the ROM
  always @(posedge clk) begin
    rom_dout1 <= rom_f(addr1);
    rom_dout2 <= rom_f(8'(addr1 + addr2));
  end

  // Scoreboard consumer
  always @(posedge clk) begin
    #1;
    if (rst && sample_valid) begin
      n_checks++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL sample_unexpected: got %h/%h with nothing expected", sample1, sample2);
      end else begin
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        if (sample1 !== e1 || sample2 !== e2) begin
          n_fail++;
          $display("FAIL sample_pair: got %h/%h expected %h/%h", sample1, sample2, e1, e2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a1, input logic [7:0] a2);
    exp1_q.push_back(rom_f(a1));
    exp2_q.push_back(rom_f(8'(a1 + a2)));
  endtask

  task automatic do_reset();
    en = 1'b0;
    cfg_valid = 1'b0;
    rst = 1'b0;
    step();
    step();
    exp1_q.delete();
    exp2_q.delete();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if ({addr1, addr2, sample1, sample2} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00000000", {addr1, addr2, sample1, sample2});
    end
    n_checks++;
    if ({cfg_ready, sample_valid, wrap, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 1000", {cfg_ready, sample_valid, wrap, busy});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_default_run();
    logic [7:0] ea;
    en = 1'b1;
    step();
    for (int i = 0; i <= 256; i++) begin
      ea = 8'(i);
      n_checks++;
      if (addr1 !== ea || addr2 !== 8'd0 || wrap !== 1'(i == 256) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL default_seq[%0d]: got a1=%0d a2=%0d wrap=%b busy=%b expected a1=%0d a2=0 wrap=%b busy=1",
                 i, addr1, addr2, wrap, busy, ea, (i == 256));
      end
      if (i < 2) begin
        n_checks++;
        if (sample_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL default_latency[%0d]: sample_valid=%b expected 0", i, sample_valid);
        end
      end
      push_exp(ea, 8'd0);
      if (i == 256) en = 1'b0;
      step();
    end
    repeat (3) step();
    n_checks++;
    if (exp1_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL default_drain: left=%0d busy=%b expected left=0 busy=0", exp1_q.size(), busy);
    end
  endtask

  task automatic test_idle_cfg();
    logic [7:0] ea;
    do_reset();
    cfg_incr = 8'd64;
    cfg_offset = 8'd32;
    cfg_valid = 1'b1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (addr1 !== 8'd0 || addr2 !== 8'd32) begin
      n_fail++;
      $display("FAIL idle_load: got a1=%0d a2=%0d expected a1=0 a2=32", addr1, addr2);
    end
    en = 1'b1;
    step();
    for (int i = 0; i <= 8; i++) begin
      ea = 8'(i * 64);
      n_checks++;
      if (addr1 !== ea || addr2 !== 8'd32 || wrap !== 1'(i != 0 && i % 4 == 0)) begin
        n_fail++;
        $display("FAIL incr64_seq[%0d]: got a1=%0d a2=%0d wrap=%b expected a1=%0d a2=32 wrap=%b",
                 i, addr1, addr2, wrap, ea, (i != 0 && i % 4 == 0));
      end
      push_exp(ea, 8'd32);
      if (i == 8) en = 1'b0;
      step();
    end
    repeat (3) step();
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL incr64_drain: left=%0d expected 0", exp1_q.size());
    end
  endtask

  task automatic test_pending_wrap();
    logic [7:0] ea1 [9] = '{8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd3, 8'd6, 8'd9};
    logic [7:0] ea2 [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd16, 8'd16, 8'd16};
    logic       ew  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       er  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 250; i++) begin
      n_checks++;
      if (addr1 !== 8'(i)) begin
        n_fail++;
        $display("FAIL pend_ramp[%0d]: got a1=%0d expected %0d", i, addr1, i);
      end
      push_exp(8'(i), 8'd0);
      step();
    end
    n_checks++;
    if (addr1 !== 8'd250 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_offer: got a1=%0d ready=%b expected a1=250 ready=1", addr1, cfg_ready);
    end
    push_exp(8'd250, 8'd0);
    cfg_incr = 8'd3;
    cfg_offset = 8'd16;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      n_checks++;
      if (addr1 !== ea1[j] || addr2 !== ea2[j] || wrap !== ew[j] || cfg_ready !== er[j]) begin
        n_fail++;
        $display("FAIL pend_seq[%0d]: got a1=%0d a2=%0d wrap=%b ready=%b expected a1=%0d a2=%0d wrap=%b ready=%b",
                 j, addr1, addr2, wrap, cfg_ready, ea1[j], ea2[j], ew[j], er[j]);
      end
      push_exp(ea1[j], ea2[j]);
      if (j == 8) en = 1'b0;
      step();
    end
    repeat (3) step();
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL pend_drain: left=%0d expected 0", exp1_q.size());
    end
  endtask

  task automatic test_cfg_on_wrap_edge();
    logic [7:0] ea1 [7] = '{8'd0, 8'd128, 8'd0, 8'd128, 8'd0, 8'd64, 8'd128};
    logic [7:0] ea2 [7] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd7, 8'd7};
    logic       ew  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       er  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    cfg_incr = 8'd128;
    cfg_offset = 8'd0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    en = 1'b1;
    step();
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (addr1 !== ea1[j] || addr2 !== ea2[j] || wrap !== ew[j] || cfg_ready !== er[j]) begin
        n_fail++;
        $display("FAIL coinc_seq[%0d]: got a1=%0d a2=%0d wrap=%b ready=%b expected a1=%0d a2=%0d wrap=%b ready=%b",
                 j, addr1, addr2, wrap, cfg_ready, ea1[j], ea2[j], ew[j], er[j]);
      end
      push_exp(ea1[j], ea2[j]);
      if (j == 1) begin
        cfg_incr = 8'd64;
        cfg_offset = 8'd7;
        cfg_valid = 1'b1;
      end
      if (j == 2) cfg_valid = 1'b0;
      if (j == 6) en = 1'b0;
      step();
    end
    repeat (3) step();
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL coinc_drain: left=%0d expected 0", exp1_q.size());
    end
  endtask

  task automatic test_stop_resume();
    int pulses = 0;
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i <= 40; i++) begin
      push_exp(8'(i), 8'd0);
      if (i == 40) begin
        n_checks++;
        if (addr1 !== 8'd40) begin
          n_fail++;
          $display("FAIL stop_at: got a1=%0d expected 40", addr1);
        end
        en = 1'b0;
      end
      step();
    end
    pulses += int'(sample_valid);
    n_checks++;
    if (addr1 !== 8'd41 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain1: got a1=%0d busy=%b expected a1=41 busy=1", addr1, busy);
    end
    en = 1'b1;
    step();
    pulses += int'(sample_valid);
    n_checks++;
    if (addr1 !== 8'd41 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain2: got a1=%0d busy=%b expected a1=41 busy=1", addr1, busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b0 || addr1 !== 8'd41) begin
      n_fail++;
      $display("FAIL drain_idle: got busy=%b valid=%b a1=%0d expected 0 0 41", busy, sample_valid, addr1);
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL drain_pulses: got %0d expected 2", pulses);
    end
    n_checks++;
    if (sample1 !== rom_f(8'd40) || sample2 !== rom_f(8'd40)) begin
      n_fail++;
      $display("FAIL sample_hold: got %h/%h expected %h/%h", sample1, sample2, rom_f(8'd40), rom_f(8'd40));
    end
    step();
    n_checks++;
    if (addr1 !== 8'd41 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got a1=%0d busy=%b expected a1=41 busy=1", addr1, busy);
    end
    push_exp(8'd41, 8'd0);
    step();
    n_checks++;
    if (addr1 !== 8'd42) begin
      n_fail++;
      $display("FAIL resume_step: got a1=%0d expected 42", addr1);
    end
    push_exp(8'd42, 8'd0);
    en = 1'b0;
    step();
    repeat (3) step();
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL resume_drain: left=%0d expected 0", exp1_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_incr = 8'd1;
    cfg_offset = 8'd9;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    en = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (addr1 !== 8'(i) || addr2 !== 8'd9) begin
        n_fail++;
        $display("FAIL arst_ramp[%0d]: got a1=%0d a2=%0d expected a1=%0d a2=9", i, addr1, addr2, i);
      end
      push_exp(8'(i), 8'd9);
      step();
    end
    n_checks++;
    if (busy !== 1'b1 || sample_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got busy=%b valid=%b expected 1 1", busy, sample_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({addr1, addr2} !== 16'h0 || {sample_valid, busy, wrap} !== 3'b000) begin
      n_fail++;
      $display("FAIL arst_immediate: got a1=%0d a2=%0d valid=%b busy=%b wrap=%b expected all 0",
               addr1, addr2, sample_valid, busy, wrap);
    end
    exp1_q.delete();
    exp2_q.delete();
    en = 1'b0;
    #2;
    rst = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || addr1 !== 8'd0 || sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_idle: got busy=%b ready=%b a1=%0d valid=%b expected 0 1 0 0",
               busy, cfg_ready, addr1, sample_valid);
    end
    en = 1'b1;
    step();
    push_exp(8'd0, 8'd0);
    step();
    n_checks++;
    if (addr1 !== 8'd1 || addr2 !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_incr: got a1=%0d a2=%0d expected a1=1 a2=0", addr1, addr2);
    end
    push_exp(8'd1, 8'd0);
    en = 1'b0;
    step();
    repeat (3) step();
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL arst_drain: left=%0d expected 0", exp1_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_idle_cfg();
    test_pending_wrap();
    test_cfg_on_wrap_edge();
    test_stop_resume();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
